// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared glyph table, vector layout and decoder for the segment readback path
package seg_pkg;

    // Segment bit positions inside a 7-bit segment field (a..g).
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] M_A = 7'(1 << SEG_A);
    localparam logic [6:0] M_B = 7'(1 << SEG_B);
    localparam logic [6:0] M_C = 7'(1 << SEG_C);
    localparam logic [6:0] M_D = 7'(1 << SEG_D);
    localparam logic [6:0] M_E = 7'(1 << SEG_E);
    localparam logic [6:0] M_F = 7'(1 << SEG_F);
    localparam logic [6:0] M_G = 7'(1 << SEG_G);

    // Active-high glyphs (lit segment = 1).
    localparam logic [6:0] GLYPH_0 = M_A | M_B | M_C | M_D | M_E | M_F;
    localparam logic [6:0] GLYPH_1 = M_B | M_C;
    localparam logic [6:0] GLYPH_2 = M_A | M_B | M_D | M_E | M_G;
    localparam logic [6:0] GLYPH_3 = M_A | M_B | M_C | M_D | M_G;
    localparam logic [6:0] GLYPH_4 = M_B | M_C | M_F | M_G;
    localparam logic [6:0] GLYPH_5 = M_A | M_C | M_D | M_F | M_G;
    localparam logic [6:0] GLYPH_6 = M_A | M_C | M_D | M_E | M_F | M_G;
    localparam logic [6:0] GLYPH_7 = M_A | M_B | M_C;
    localparam logic [6:0] GLYPH_8 = M_A | M_B | M_C | M_D | M_E | M_F | M_G;
    localparam logic [6:0] GLYPH_9 = M_A | M_B | M_C | M_D | M_F | M_G;
    localparam logic [6:0] GLYPH_A = M_A | M_B | M_C | M_E | M_F | M_G;
    localparam logic [6:0] GLYPH_B = M_C | M_D | M_E | M_F | M_G;
    localparam logic [6:0] GLYPH_C = M_A | M_D | M_E | M_F;
    localparam logic [6:0] GLYPH_D = M_B | M_C | M_D | M_E | M_G;
    localparam logic [6:0] GLYPH_E = M_A | M_D | M_E | M_F | M_G;
    localparam logic [6:0] GLYPH_F = M_A | M_E | M_F | M_G;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Sample vector layout: {seg1_dpt, seg1, seg0_dpt, seg0}.
    localparam int SAMP_W   = 16;
    localparam int SEG0_LSB = 0;
    localparam int DP0_BIT  = 7;
    localparam int SEG1_LSB = 8;
    localparam int DP1_BIT  = 15;

    typedef enum logic {ST_EMPTY, ST_LOCKED} state_t;

    typedef struct packed {
        logic       valid;
        logic       blank;
        logic [3:0] digit;
    } seg_dec_t;

    // Takes the raw active-low segment lines; non-glyph, non-blank returns all zero.
    function automatic seg_dec_t seg_decode(input logic [6:0] seg_n);
        logic [6:0] g;
        seg_dec_t   r;
        g = ~seg_n;
        r = '0;
        case (g)
            GLYPH_0:   begin r.valid = 1'b1; r.digit = 4'h0; end
            GLYPH_1:   begin r.valid = 1'b1; r.digit = 4'h1; end
            GLYPH_2:   begin r.valid = 1'b1; r.digit = 4'h2; end
            GLYPH_3:   begin r.valid = 1'b1; r.digit = 4'h3; end
            GLYPH_4:   begin r.valid = 1'b1; r.digit = 4'h4; end
            GLYPH_5:   begin r.valid = 1'b1; r.digit = 4'h5; end
            GLYPH_6:   begin r.valid = 1'b1; r.digit = 4'h6; end
            GLYPH_7:   begin r.valid = 1'b1; r.digit = 4'h7; end
            GLYPH_8:   begin r.valid = 1'b1; r.digit = 4'h8; end
            GLYPH_9:   begin r.valid = 1'b1; r.digit = 4'h9; end
            GLYPH_A:   begin r.valid = 1'b1; r.digit = 4'hA; end
            GLYPH_B:   begin r.valid = 1'b1; r.digit = 4'hB; end
            GLYPH_C:   begin r.valid = 1'b1; r.digit = 4'hC; end
            GLYPH_D:   begin r.valid = 1'b1; r.digit = 4'hD; end
            GLYPH_E:   begin r.valid = 1'b1; r.digit = 4'hE; end
            GLYPH_F:   begin r.valid = 1'b1; r.digit = 4'hF; end
            SEG_BLANK: r.blank = 1'b1;
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg_stable_filter.sv
// rtl/seg_stable_filter.sv - glitch filter that strobes once when a sample vector has been stable long enough
module seg_stable_filter
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SAMP_W-1:0] samp_i,
    output logic              stable_new_o,
    output logic [SAMP_W-1:0] vec_o
);

    localparam logic [7:0] RUN_MAX = 8'(STABLE_CYCLES);

    logic [SAMP_W-1:0] samp_q;
    logic [SAMP_W-1:0] prev_q;
    logic [7:0]        run_q;
    logic [7:0]        run_d;

    // Run length restarts on any change, otherwise counts up and saturates at the window.
    always_comb begin
        run_d = run_q;
        if (samp_q != prev_q) begin
            run_d = 8'd1;
        end else if (run_q != RUN_MAX) begin
            run_d = run_q + 8'd1;
        end
    end

    // Strobe only on the transition into the window value, so a held pattern fires once.
    assign stable_new_o = (run_d == RUN_MAX) && (run_q != RUN_MAX);
    assign vec_o        = samp_q;

    // Sample pipeline; reset value is all ones so the lines look blank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_q <= '1;
            prev_q <= '1;
            run_q  <= '0;
        end else begin
            samp_q <= samp_i;
            prev_q <= samp_q;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/seg_capture.sv
// rtl/seg_capture.sv - two-digit seven-segment readback decoder with update, swap and error events
module seg_capture
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       seg0,
    input  logic [6:0]       seg1,
    input  logic             seg0_dpt,
    input  logic             seg1_dpt,
    output logic [3:0]       digit0,
    output logic [3:0]       digit1,
    output logic             valid0,
    output logic             valid1,
    output logic             dp0,
    output logic             dp1,
    output logic             upd,
    output logic             swapped,
    output logic             err,
    output logic [CNT_W-1:0] upd_cnt
);

    logic              stable_new;
    logic [SAMP_W-1:0] vec;
    logic              accept;
    seg_dec_t          dec0;
    seg_dec_t          dec1;

    state_t            state_q, state_d;
    logic [SAMP_W-1:0] acc_q, acc_d;
    logic [3:0]        digit0_q, digit0_d, digit1_q, digit1_d;
    logic              valid0_q, valid0_d, valid1_q, valid1_d;
    logic              dp0_q, dp0_d, dp1_q, dp1_d;
    logic              upd_q, upd_d, swapped_q, swapped_d, err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    seg_stable_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk         (clk),
        .rst         (rst),
        .samp_i      ({seg1_dpt, seg1, seg0_dpt, seg0}),
        .stable_new_o(stable_new),
        .vec_o       (vec)
    );

    // A stable pattern is only news if nothing is held yet or it differs from what is held.
    assign accept = stable_new && ((state_q == ST_EMPTY) || (vec != acc_q));

    // Next-state and event logic: load decoded pair and raise pulses on acceptance.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        digit0_d  = digit0_q;
        digit1_d  = digit1_q;
        valid0_d  = valid0_q;
        valid1_d  = valid1_q;
        dp0_d     = dp0_q;
        dp1_d     = dp1_q;
        upd_d     = 1'b0;
        swapped_d = 1'b0;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        dec0      = seg_decode(vec[SEG0_LSB +: 7]);
        dec1      = seg_decode(vec[SEG1_LSB +: 7]);
        if (accept) begin
            state_d   = ST_LOCKED;
            acc_d     = vec;
            digit0_d  = dec0.digit;
            digit1_d  = dec1.digit;
            valid0_d  = dec0.valid;
            valid1_d  = dec1.valid;
            dp0_d     = ~vec[DP0_BIT];
            dp1_d     = ~vec[DP1_BIT];
            upd_d     = 1'b1;
            cnt_d     = cnt_q + CNT_W'(1);
            err_d     = (!dec0.valid && !dec0.blank) || (!dec1.valid && !dec1.blank);
            // Decimal points deliberately play no part in the swap test.
            swapped_d = (state_q == ST_LOCKED) && valid0_q && valid1_q &&
                        (digit0_q != digit1_q) && dec0.valid && dec1.valid &&
                        (dec0.digit == digit1_q) && (dec1.digit == digit0_q);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            acc_q     <= '1;
            digit0_q  <= '0;
            digit1_q  <= '0;
            valid0_q  <= 1'b0;
            valid1_q  <= 1'b0;
            dp0_q     <= 1'b0;
            dp1_q     <= 1'b0;
            upd_q     <= 1'b0;
            swapped_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            digit0_q  <= digit0_d;
            digit1_q  <= digit1_d;
            valid0_q  <= valid0_d;
            valid1_q  <= valid1_d;
            dp0_q     <= dp0_d;
            dp1_q     <= dp1_d;
            upd_q     <= upd_d;
            swapped_q <= swapped_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign digit0  = digit0_q;
    assign digit1  = digit1_q;
    assign valid0  = valid0_q;
    assign valid1  = valid1_q;
    assign dp0     = dp0_q;
    assign dp1     = dp1_q;
    assign upd     = upd_q;
    assign swapped = swapped_q;
    assign err     = err_q;
    assign upd_cnt = cnt_q;

endmodule

// File: tb/tb_seg_capture.sv
// tb/tb_seg_capture.sv - directed self-checking bench for seg_capture
module tb_seg_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg0, seg1;
    logic       seg0_dpt, seg1_dpt;
    logic [3:0] digit0, digit1;
    logic       valid0, valid1, dp0, dp1, upd, swapped, err;
    logic [7:0] upd_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int stray  = 0;

    seg_capture #(
        .STABLE_CYCLES(4),
        .CNT_W        (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .seg0    (seg0),
        .seg1    (seg1),
        .seg0_dpt(seg0_dpt),
        .seg1_dpt(seg1_dpt),
        .digit0  (digit0),
        .digit1  (digit1),
        .valid0  (valid0),
        .valid1  (valid1),
        .dp0     (dp0),
        .dp1     (dp1),
        .upd     (upd),
        .swapped (swapped),
        .err     (err),
        .upd_cnt (upd_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] s0, s1;
        logic       d0n, d1n;
        int         hold;
        int         e_upd;
        logic       e_sw, e_err;
        logic [3:0] e_d0, e_d1;
        logic       e_v0, e_v1, e_dp0, e_dp1;
        int         e_cnt;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(input logic [6:0] s0, input logic [6:0] s1,
                                input logic d0n, input logic d1n, input int hold,
                                input int u, input logic sw, input logic er,
                                input logic [3:0] dd0, input logic [3:0] dd1,
                                input logic v0, input logic v1,
                                input logic p0, input logic p1, input int cnt);
        vec_t v;
        v.s0 = s0; v.s1 = s1; v.d0n = d0n; v.d1n = d1n; v.hold = hold;
        v.e_upd = u; v.e_sw = sw; v.e_err = er; v.e_d0 = dd0; v.e_d1 = dd1;
        v.e_v0 = v0; v.e_v1 = v1; v.e_dp0 = p0; v.e_dp1 = p1; v.e_cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] s0, input logic [6:0] s1, input logic d0n, input logic d1n);
        seg0 = s0; seg1 = s1; seg0_dpt = d0n; seg1_dpt = d1n;
    endtask

    task automatic window(input int n, output int nu, output logic sw, output logic er);
        nu = 0; sw = 1'b0; er = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            if (upd) nu++;
            if (swapped) sw = 1'b1;
            if (err) er = 1'b1;
            if ((swapped || err) && !upd) stray++;
        end
    endtask

    task automatic chk_outputs(input string tag, input logic [3:0] d0, input logic [3:0] d1,
                               input logic v0, input logic v1, input logic p0, input logic p1,
                               input int cnt);
        chk({tag, "_digit0"}, 32'(digit0), 32'(d0));
        chk({tag, "_digit1"}, 32'(digit1), 32'(d1));
        chk({tag, "_valid0"}, 32'(valid0), 32'(v0));
        chk({tag, "_valid1"}, 32'(valid1), 32'(v1));
        chk({tag, "_dp0"}, 32'(dp0), 32'(p0));
        chk({tag, "_dp1"}, 32'(dp1), 32'(p1));
        chk({tag, "_upd_cnt"}, 32'(upd_cnt), 32'(cnt));
    endtask

    initial begin
        int   nu;
        logic sw, er;
        int   total;

        // Raw active-low lines: ~3F=40 (0), ~06=79 (1), ~5B=24 (2), ~7F=00 (8), 7F blank, 55 illegal.
        tbl[0]  = mk(7'h00, 7'h79, 1, 1, 3, 0, 0, 0, 4'h0, 4'h1, 1, 1, 0, 0, 1);
        tbl[1]  = mk(7'h40, 7'h79, 1, 1, 8, 0, 0, 0, 4'h0, 4'h1, 1, 1, 0, 0, 1);
        tbl[2]  = mk(7'h79, 7'h40, 1, 1, 8, 1, 1, 0, 4'h1, 4'h0, 1, 1, 0, 0, 2);
        tbl[3]  = mk(7'h79, 7'h55, 1, 1, 8, 1, 0, 1, 4'h1, 4'h0, 1, 0, 0, 0, 3);
        tbl[4]  = mk(7'h7F, 7'h7F, 1, 1, 8, 1, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 4);
        tbl[5]  = mk(7'h40, 7'h24, 1, 1, 8, 1, 0, 0, 4'h0, 4'h2, 1, 1, 0, 0, 5);
        tbl[6]  = mk(7'h40, 7'h24, 0, 1, 8, 1, 0, 0, 4'h0, 4'h2, 1, 1, 1, 0, 6);
        tbl[7]  = mk(7'h40, 7'h24, 1, 1, 8, 1, 0, 0, 4'h0, 4'h2, 1, 1, 0, 0, 7);
        tbl[8]  = mk(7'h24, 7'h40, 1, 0, 8, 1, 1, 0, 4'h2, 4'h0, 1, 1, 0, 1, 8);
        tbl[9]  = mk(7'h24, 7'h24, 1, 1, 8, 1, 0, 0, 4'h2, 4'h2, 1, 1, 0, 0, 9);
        tbl[10] = mk(7'h40, 7'h79, 1, 1, 8, 1, 0, 0, 4'h0, 4'h1, 1, 1, 0, 0, 10);
        tbl[11] = mk(7'h79, 7'h40, 1, 1, 8, 1, 1, 0, 4'h1, 4'h0, 1, 1, 0, 0, 11);

        // Reset state.
        rst = 1'b1;
        drive(7'h40, 7'h79, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk_outputs("reset", 4'h0, 4'h0, 0, 0, 0, 0, 0);
        chk("reset_upd", 32'(upd), 0);
        chk("reset_swapped", 32'(swapped), 0);
        chk("reset_err", 32'(err), 0);

        // First acceptance latency: upd exactly after the fifth edge, for one cycle.
        rst = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk); #1;
            chk($sformatf("lat_upd_edge%0d", e), 32'(upd), 32'(e == 5));
        end
        chk_outputs("first", 4'h0, 4'h1, 1, 1, 0, 0, 1);

        // Table: glitch, restore, swap, illegal, blank, dps, non-swap with equal old digits.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].s0, tbl[i].s1, tbl[i].d0n, tbl[i].d1n);
            window(tbl[i].hold, nu, sw, er);
            chk($sformatf("v%0d_upd_count", i), 32'(nu), 32'(tbl[i].e_upd));
            chk($sformatf("v%0d_swapped", i), 32'(sw), 32'(tbl[i].e_sw));
            chk($sformatf("v%0d_err", i), 32'(er), 32'(tbl[i].e_err));
            chk_outputs($sformatf("v%0d", i), tbl[i].e_d0, tbl[i].e_d1, tbl[i].e_v0, tbl[i].e_v1,
                        tbl[i].e_dp0, tbl[i].e_dp1, tbl[i].e_cnt);
        end

        // Decimal point low for exactly four samples is accepted on the edge after it returns.
        drive(7'h79, 7'h40, 1'b0, 1'b1);
        window(4, nu, sw, er);
        chk("dp4_no_early_upd", 32'(nu), 0);
        drive(7'h79, 7'h40, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("dp4_upd", 32'(upd), 1);
        chk("dp4_swapped", 32'(swapped), 0);
        chk_outputs("dp4", 4'h1, 4'h0, 1, 1, 1, 0, 12);
        window(8, nu, sw, er);
        chk("dp4_return_upd_count", 32'(nu), 1);
        chk_outputs("dp4_return", 4'h1, 4'h0, 1, 1, 0, 0, 13);

        // Counter wrap after 256 acceptances from reset.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total = 0;
        for (int i = 0; i < 256; i++) begin
            if (i % 2 == 0) drive(7'h40, 7'h79, 1'b1, 1'b1);
            else            drive(7'h79, 7'h40, 1'b1, 1'b1);
            window(6, nu, sw, er);
            total += nu;
        end
        chk("wrap_upd_total", 32'(total), 256);
        chk("wrap_upd_cnt", 32'(upd_cnt), 0);

        // One more acceptance with both dps lit, then reset two samples into a new pattern.
        drive(7'h24, 7'h24, 1'b0, 1'b0);
        window(6, nu, sw, er);
        chk_outputs("pre_rst", 4'h2, 4'h2, 1, 1, 1, 1, 1);
        drive(7'h40, 7'h79, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_outputs("mid_rst", 4'h0, 4'h0, 0, 0, 0, 0, 0);
        chk("mid_rst_upd", 32'(upd), 0);

        // Blank held after reset is still a first acceptance, with no error.
        drive(7'h7F, 7'h7F, 1'b1, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
            chk($sformatf("blank_upd_edge%0d", e), 32'(upd), 32'(e == 4));
            chk($sformatf("blank_err_edge%0d", e), 32'(err), 0);
        end
        chk_outputs("blank", 4'h0, 4'h0, 0, 0, 0, 0, 1);

        chk("pulse_without_upd", 32'(stray), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_capture.md
# seg_capture

Seven-segment readback decoder for the two-digit display path. It samples the segment and decimal-point lines driven to a pair of displays, filters glitches with a stability window, and decodes each stable pattern back to a 4-bit hex digit. It reports update, swap and error events. It sits beside the display driver in self-checking top levels and on the bench side of board-level tests.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a pattern is accepted; legal range 2–255.
- `CNT_W`, default 8: width of the update counter.

Ports (clock and reset first):
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset; asynchronous, active-high.
- `seg0` in 7: display 0 segments, active-low; bit0=a … bit6=g.
- `seg1` in 7: display 1 segments, same encoding as `seg0`.
- `seg0_dpt` in 1: display 0 decimal point, active-low.
- `seg1_dpt` in 1: display 1 decimal point, active-low.
- `digit0` out 4: last accepted decoded value, display 0.
- `digit1` out 4: last accepted decoded value, display 1.
- `valid0` out 1: accepted display 0 pattern is a legal hex glyph.
- `valid1` out 1: accepted display 1 pattern is a legal hex glyph.
- `dp0` out 1: accepted decimal point 0, active-high (lit = 1).
- `dp1` out 1: accepted decimal point 1, active-high (lit = 1).
- `upd` out 1: one-cycle pulse when a new pair is accepted.
- `swapped` out 1: one-cycle pulse, coincident with `upd`, when the new pair is the old pair exchanged.
- `err` out 1: one-cycle pulse, coincident with `upd`, when either accepted pattern is neither a glyph nor blank.
- `upd_cnt` out `CNT_W`: number of `upd` pulses since reset; wraps.

## Operation
- Sample vector S = {seg1_dpt, seg1, seg0_dpt, seg0}, 16 bits. It is registered every cycle into `samp`, and the previous `samp` is held in `prev`.
- Run counter `run`:
  - `samp != prev` → `run` = 1.
  - Otherwise `run` increments, saturating at `STABLE_CYCLES`.
- FSM states:
  - EMPTY: nothing accepted since reset.
  - LOCKED: a pair has been accepted.
- Acceptance fires when `run` reaches `STABLE_CYCLES` (the transition into that value) and either the state is EMPTY or `samp` differs from the accepted vector. On acceptance:
  - The accepted vector and decoded outputs are loaded.
  - `upd` pulses and `upd_cnt` increments.
  - EMPTY→LOCKED.
- A stable pattern equal to the accepted vector produces no event.
- Decode uses active-high glyphs (segments inverted). Legal glyphs: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Blank (all segments off) → `valid`=0, digit=0, no error.
- Any other pattern → `valid`=0, digit=0, `err` pulses.
- `swapped` requires all of the following:
  - State was LOCKED.
  - Old pair has both `valid`=1 and `digit0 != digit1`.
  - New pair has both `valid`=1.
  - New `digit0` = old `digit1` and new `digit1` = old `digit0`.
- Decimal points are ignored for the `swapped` check but do count as a change for acceptance.

## Timing
- Reset values: `digit0/1`=0, `valid0/1`=0, `dp0/1`=0, `upd`=0, `swapped`=0, `err`=0, `upd_cnt`=0, `run`=0, state EMPTY, `samp`/`prev` all ones (blank).
- Latency: input stable from before edge t → outputs and `upd` valid after edge t+`STABLE_CYCLES`. `upd` is high for exactly that one cycle.
- A change lasting fewer than `STABLE_CYCLES` samples is discarded; the outputs hold their previous value.
- A change arriving in the same cycle acceptance would have fired means `run` did not reach the threshold, so there is no acceptance.
- Holding a pattern indefinitely yields exactly one `upd`.
- Returning to an older pattern after a different pattern was accepted is a new acceptance.
- `upd_cnt` wraps from 2^`CNT_W`−1 to 0 with no flag.
- Asserting `rst` mid-window clears everything immediately; the first stable pattern after release is always accepted, including blank.

## Structure
- Shared package `seg_pkg`:
  - 7-bit glyph constants 0–F.
  - `SEG_BLANK`.
  - Segment bit-index constants.
  - Function `seg_decode` returning {valid, blank, digit}.
- Sub-module `seg_stable_filter` (parameter `STABLE_CYCLES`): the `samp`/`prev`/`run` logic, emitting a one-cycle `stable_new` strobe plus the vector.
- The top level holds the FSM, decode, swap/error logic and counter.

## Test plan
- Reset, then hold seg0=~3F, seg1=~06, dps high (off) → one `upd` after 1+4 edges; digit0=0, digit1=1, `valid0/1`=1, `upd_cnt`=1.
- 3-cycle glitch seg0=~7F, then back to ~3F → no `upd`; outputs unchanged.
- From the (0,1) state, apply seg0=~06, seg1=~3F → `upd` and `swapped`=1 in the same cycle; `err`=0.
- Apply seg1=0x55 (illegal) → `upd` and `err` pulse; `valid1`=0, digit1=0. Then apply all-ones blank → `upd` with no `err`.
- Toggle `seg0_dpt` low for 4 cycles → `upd`, `dp0`=1, `swapped`=0, digits unchanged.
- Run 256 alternating stable patterns with `CNT_W`=8 → `upd_cnt` returns to 0. Assert `rst` at `run`=2 → all outputs reach their reset values immediately.
